// File: rtl/axis_datapoint_packetizer_if.sv
// Bundles the datapoint-in handshake and the m00 AXI-Stream beat bus.
// master = packetizer side, slave = source/sink side.
interface axis_datapoint_packetizer_if #(
    parameter int C_M00_AXIS_DATA_WIDTH = 64,
    parameter int NUM_PACKETS           = 13
);
    logic                                           dp_valid;
    logic                                           dp_ready;
    logic [NUM_PACKETS*C_M00_AXIS_DATA_WIDTH-1:0]   dp_data;
    logic                                           m00_axis_tvalid;
    logic                                           m00_axis_tready;
    logic [C_M00_AXIS_DATA_WIDTH-1:0]               m00_axis_tdata;
    logic [C_M00_AXIS_DATA_WIDTH/8-1:0]             m00_axis_tstrb;
    logic                                           m00_axis_tlast;
    logic                                           batch_done;

    modport master (
        input  dp_valid, dp_data, m00_axis_tready,
        output dp_ready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb,
               m00_axis_tlast, batch_done
    );

    modport slave (
        output dp_valid, dp_data, m00_axis_tready,
        input  dp_ready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb,
               m00_axis_tlast, batch_done
    );
endinterface

// File: rtl/axis_datapoint_packetizer.sv
// Serialises one NUM_PACKETS-word datapoint per handshake into m00 beats; tlast ends each batch of DATAPOINTS (every datapoint if AXIS_TLAST_PER_DATAPOINT_EN).
// Latency: beat 0 is valid the cycle after the datapoint is accepted; consecutive datapoints stream with no bubble.
// Backpressure: tready low freezes beat, counters and payload; dp_ready only in IDLE or on the last-beat handshake.
module axis_datapoint_packetizer #(
    parameter int C_M00_AXIS_DATA_WIDTH = 64,
    parameter int NUM_PACKETS           = 13,
    parameter int DATAPOINTS            = 10
) (
    input  logic                        m00_axis_aclk,
    input  logic                        m00_axis_aresetn,
    axis_datapoint_packetizer_if.master bus
);
    localparam int W      = C_M00_AXIS_DATA_WIDTH;
    localparam int BEAT_W = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
    localparam int DP_W   = (DATAPOINTS > 1) ? $clog2(DATAPOINTS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_PACKETS - 1);
    localparam logic [DP_W-1:0]   LAST_DP   = DP_W'(DATAPOINTS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DP_W-1:0]     dp_q, dp_d;
    logic                done_q, done_d;
    logic                load;
    logic                dp_ready;
    logic                tvalid;
    logic                tlast;
    logic                is_last_beat;
    logic                is_last_dp;
    logic                tlast_sel;
    logic [W-1:0]        words_q [NUM_PACKETS];

    assign is_last_beat = (beat_q == LAST_BEAT);
    assign is_last_dp   = (dp_q == LAST_DP);

`ifdef AXIS_TLAST_PER_DATAPOINT_EN
    assign tlast_sel = 1'b1;
`else
    assign tlast_sel = is_last_dp;
`endif

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        dp_d     = dp_q;
        done_d   = 1'b0;
        load     = 1'b0;
        dp_ready = 1'b0;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        case (state_q)
            IDLE: begin
                dp_ready = 1'b1;
                if (bus.dp_valid) begin
                    load    = 1'b1;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tvalid = 1'b1;
                tlast  = is_last_beat && tlast_sel;
                if (bus.m00_axis_tready) begin
                    if (!is_last_beat) begin
                        beat_d = beat_q + 1'b1;
                    end else begin
                        // Batch counting stays per batch even when tlast fires every datapoint.
                        dp_d     = is_last_dp ? '0 : dp_q + 1'b1;
                        done_d   = is_last_dp;
                        dp_ready = 1'b1;
                        beat_d   = '0;
                        if (bus.dp_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            dp_q    <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NUM_PACKETS; k++) begin
                words_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            dp_q    <= dp_d;
            done_q  <= done_d;
            if (load) begin
                for (int k = 0; k < NUM_PACKETS; k++) begin
                    words_q[k] <= bus.dp_data[k*W +: W];
                end
            end
        end
    end

    assign bus.dp_ready        = dp_ready;
    assign bus.m00_axis_tvalid = tvalid;
    assign bus.m00_axis_tlast  = tlast;
    assign bus.m00_axis_tdata  = words_q[beat_q];
    assign bus.m00_axis_tstrb  = '1;
    assign bus.batch_done      = done_q;
endmodule

// File: doc/axis_datapoint_packetizer.md
# axis_datapoint_packetizer

Upstream feeder for `axis_wrapper_top`. Accepts one full datapoint (NUM_PACKETS × 64-bit words of boolean features) per valid/ready handshake, serialises it into NUM_PACKETS AXI-Stream beats on the `m00` master port, and asserts `tlast` on the final beat of every batch of DATAPOINTS datapoints. It replaces bench-side beat sequencing with synthesizable logic between the host-side datapoint source and the accelerator's `s00_axis` slave.

## Interface
- `C_M00_AXIS_DATA_WIDTH`, 64, beat width in bits.
- `NUM_PACKETS`, 13, beats per datapoint (≥1).
- `DATAPOINTS`, 10, datapoints per batch (≥1); batch end is marked by `tlast`.

- `m00_axis_aclk`  in  1  sole clock, rising edge.
- `m00_axis_aresetn`  in  1  synchronous, active-low reset.
- `dp_valid`  in  1  datapoint source valid.
- `dp_ready`  out  1  packetizer can accept a datapoint this cycle.
- `dp_data`  in  NUM_PACKETS*C_M00_AXIS_DATA_WIDTH  datapoint; word k = bits [k*W +: W], W = C_M00_AXIS_DATA_WIDTH.
- `m00_axis_tvalid`  out  1  beat valid.
- `m00_axis_tready`  in  1  downstream ready.
- `m00_axis_tdata`  out  W  beat payload.
- `m00_axis_tstrb`  out  W/8  constant all-ones.
- `m00_axis_tlast`  out  1  final beat of batch.
- `batch_done`  out  1  one-cycle pulse after the batch's `tlast` beat handshakes.

## Operation
- FSM states: IDLE, SEND.
- IDLE: `dp_ready`=1, `m00_axis_tvalid`=0. On `dp_valid && dp_ready`: load `dp_data` into the internal buffer, beat_cnt←0, go to SEND.
- SEND: `m00_axis_tvalid`=1, `tdata` = buffer word beat_cnt (word 0 first). On beat handshake (`tvalid && tready`):
  - beat_cnt < NUM_PACKETS-1: beat_cnt++.
  - beat_cnt = NUM_PACKETS-1 (last beat): dp_cnt++ (wraps to 0 after DATAPOINTS-1). If `dp_valid` is high, the next datapoint loads in the same cycle, beat_cnt←0, and the FSM stays in SEND. Otherwise it goes to IDLE.
- `dp_ready` = IDLE, or (SEND and last beat and `m00_axis_tready`). This gives back-to-back datapoints with no bubble.
- `m00_axis_tlast` = SEND and beat_cnt = NUM_PACKETS-1 and dp_cnt = DATAPOINTS-1.
- `batch_done` is registered. It is 1 in the cycle after the `tlast` beat handshakes.
- Counter widths: beat_cnt is $clog2(NUM_PACKETS) bits and dp_cnt is $clog2(DATAPOINTS) bits, each with a minimum of 1 bit. Compare explicitly at the terminal value; do not rely on power-of-two wrap.

## Timing
- Reset values: `m00_axis_tvalid`=0, `m00_axis_tlast`=0, `batch_done`=0, `m00_axis_tdata`=0, FSM=IDLE, beat_cnt=0, dp_cnt=0. `dp_ready`=1 in the first cycle after reset deasserts.
- Latency: datapoint accepted at edge N → beat 0 valid from cycle N+1. Each datapoint takes exactly NUM_PACKETS handshaked beats.
- AXI-Stream rules:
  - Once `tvalid` is high, it stays high, and `tdata`/`tlast` stay stable, until the handshake completes.
  - `tready` low stalls indefinitely with no state change.
- `dp_data` is sampled only on the load edge. It may change freely afterwards.
- Reset mid-datapoint: all state returns to reset values at the next edge. The partial datapoint is discarded and the batch count restarts at 0.
- `dp_valid` is ignored while `dp_ready`=0.

## Configuration
- `AXIS_TLAST_PER_DATAPOINT_EN`:
  - Defined: `tlast` is asserted on the last beat of every datapoint, and `batch_done` still pulses only at batch end.
  - Undefined (default): `tlast` is asserted only on the last beat of datapoint DATAPOINTS-1, as described above.

## Test plan
- Reset, then one datapoint with word k = 64'h1000+k, `tready`=1 → 13 consecutive beats 0x1000..0x100C starting the cycle after load; `tlast`=0 throughout; FSM returns to IDLE.
- 10 datapoints streamed back-to-back with `dp_valid` held high, `tready`=1:
  - exactly 130 beats with no gaps;
  - `tlast` only on beat 129;
  - `batch_done` pulses once, one cycle later;
  - dp_cnt wraps so the 11th datapoint starts a new batch.
- Random `tready` (50% duty) over 2 batches → `tdata`/`tlast`/`tvalid` held stable during every stall; beat sequence and `tlast` positions identical to the no-stall run.
- Reset asserted at beat 6 of datapoint 4 → `tvalid` drops the next cycle; after release, a fresh batch needs 10 full datapoints before `tlast`.
- `dp_valid` toggled while in SEND (not on the last beat) → no load, `dp_ready`=0; load occurs only on the last-beat handshake.
- With `AXIS_TLAST_PER_DATAPOINT_EN` defined, 10 datapoints → `tlast` on beats 12, 25, …, 129; `batch_done` pulses once.
